// File: rtl/addsub_op_sequencer_if.sv
// Handshake and adder-drive bundle for the add/sub sequencer.
// slave = sequencer side, master = requester/adder/consumer side.
interface addsub_op_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mode;
  logic             in_chain;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_mode;
  logic [WIDTH-1:0] add_result;
  logic             add_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_ovf;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_chain,
    input  add_result, add_carry, out_ready,
    output in_ready, add_a, add_b, add_mode,
    output out_valid, out_result, out_carry, out_ovf,
    output busy, op_count
  );

  modport master (
    output in_valid, in_a, in_b, in_mode, in_chain,
    output add_result, add_carry, out_ready,
    input  in_ready, add_a, add_b, add_mode,
    input  out_valid, out_result, out_carry, out_ovf,
    input  busy, op_count
  );
endinterface

// File: rtl/addsub_op_sequencer.sv
// Sequencer front-end for a combinational add/sub unit.
// Accepts one op, drives the adder, captures and holds the result.
module addsub_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  addsub_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_mode_q, add_mode_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] beff;

  // Next-state and registered-output computation for the op FSM.
  always_comb begin
    state_d    = state_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_mode_d = add_mode_q;
    res_d      = res_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    valid_d    = valid_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    beff       = add_mode_q ? ~add_b_q : add_b_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          add_a_d    = bus.in_chain ? last_q : bus.in_a;
          add_b_d    = bus.in_b;
          add_mode_d = bus.in_mode;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        res_d   = bus.add_result;
        carry_d = bus.add_carry;
        ovf_d   = (add_a_q[WIDTH-1] == beff[WIDTH-1]) &&
                  (bus.add_result[WIDTH-1] != add_a_q[WIDTH-1]);
        last_d  = bus.add_result;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          valid_d    = 1'b0;
          cnt_d      = cnt_q + CNT_W'(1);
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        valid_d    = 1'b0;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_mode_q <= 1'b0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_mode_q <= add_mode_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.add_mode   = add_mode_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_result = res_q;
  assign bus.out_carry  = carry_q;
  assign bus.out_ovf    = ovf_q;
  assign bus.busy       = busy_q;
  assign bus.op_count   = cnt_q;

endmodule

// File: tb/tb_addsub_op_sequencer.sv
// Bench for addsub_op_sequencer with a behavioural 4-bit adder
// and a transaction-level expectation model.
module tb_addsub_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addsub_op_sequencer_if #(.WIDTH(4), .CNT_W(8)) bus ();

  addsub_op_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [4:0] adder_sum;
  assign adder_sum = {1'b0, bus.add_a}
                   + {1'b0, bus.add_b ^ {4{bus.add_mode}}}
                   + {4'b0, bus.add_mode};
  assign bus.add_result = adder_sum[3:0];
  assign bus.add_carry  = adder_sum[4];

  int checks = 0;
  int errors = 0;

  int exp_valid, exp_res, exp_carry, exp_ovf;
  int exp_ready, exp_cnt, exp_last;
  int exp_add_a, exp_add_b, exp_add_mode;
  int seen_add_a;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               name, act, req, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v > 7) ? v - 16 : v;
  endfunction

  // Arithmetic meaning of an op, from plain integer maths.
  task automatic calc(input int a, input int b, input int m,
                      output int r, output int c, output int o);
    int s;
    if (m == 0) begin
      r = (a + b) % 16;
      c = (a + b > 15) ? 1 : 0;
      s = sx(a) + sx(b);
    end else begin
      r = (a - b + 16) % 16;
      c = (a >= b) ? 1 : 0;
      s = sx(a) - sx(b);
    end
    o = (s > 7 || s < -8) ? 1 : 0;
  endtask

  task automatic model_reset();
    exp_valid = 0; exp_res = 0; exp_carry = 0; exp_ovf = 0;
    exp_ready = 1; exp_cnt = 0; exp_last = 0;
    exp_add_a = 0; exp_add_b = 0; exp_add_mode = 0;
  endtask

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 32'(bus.out_valid), exp_valid);
      chk("out_result", 32'(bus.out_result), exp_res);
      chk("out_carry", 32'(bus.out_carry), exp_carry);
      chk("out_ovf", 32'(bus.out_ovf), exp_ovf);
      chk("in_ready", 32'(bus.in_ready), exp_ready);
      chk("busy", 32'(bus.busy), 32'(1 - exp_ready));
      chk("op_count", 32'(bus.op_count), 32'(exp_cnt % 256));
      chk("add_a", 32'(bus.add_a), exp_add_a);
      chk("add_b", 32'(bus.add_b), exp_add_b);
      chk("add_mode", 32'(bus.add_mode), exp_add_mode);
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 32'(bus.in_ready), 1);
  endtask

  task automatic run_op(input int a, input int b, input int m,
                        input int ch, input int stall,
                        input bit rst_drive);
    int ea, r, c, o;
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_a      = 4'(a);
    bus.in_b      = 4'(b);
    bus.in_mode   = m[0];
    bus.in_chain  = ch[0];
    bus.out_ready = (stall == 0);
    @(posedge clk);
    ea = (ch != 0) ? exp_last : a;
    calc(ea, b, m, r, c, o);
    exp_ready = 0;
    exp_add_a = ea; exp_add_b = b; exp_add_mode = m;
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = ~bus.in_a;
    bus.in_b     = ~bus.in_b;
    bus.in_mode  = ~bus.in_mode;
    bus.in_chain = ~bus.in_chain;
    if (rst_drive) begin
      #1 rst = 1'b1;
      model_reset();
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_op_count", 32'(bus.op_count), 0);
      chk("rst_add_a", 32'(bus.add_a), 0);
      chk("rst_out_result", 32'(bus.out_result), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      return;
    end
    @(negedge clk);
    seen_add_a = int'(bus.add_a);
    chk("lat_drive_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    exp_valid = 1; exp_res = r; exp_carry = c; exp_ovf = o;
    repeat ((stall > 0) ? stall : 1) @(negedge clk);
    chk("lat_hold_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    exp_valid = 0;
    exp_ready = 1;
    exp_cnt++;
    exp_last = r;
  endtask

  task automatic post(input int r, input int c, input int o);
    @(negedge clk);
    chk("lit_result", 32'(bus.out_result), r);
    chk("lit_carry", 32'(bus.out_carry), c);
    chk("lit_ovf", 32'(bus.out_ovf), o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_mode   = 1'b0;
    bus.in_chain  = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    #11;
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_op_count", 32'(bus.op_count), 0);
    chk("reset_add_a", 32'(bus.add_a), 0);
    chk("reset_out_result", 32'(bus.out_result), 0);
    #1 rst = 1'b0;

    run_op(2, 3, 0, 0, 0, 1'b0);
    post(5, 0, 0);
    run_op(7, 6, 0, 0, 0, 1'b0);
    post(13, 0, 1);
    run_op(8, 3, 1, 0, 0, 1'b0);
    post(5, 1, 1);
    run_op(9, 5, 1, 0, 0, 1'b0);
    post(4, 1, 1);
    run_op(3, 5, 1, 0, 0, 1'b0);
    post(14, 0, 0);

    run_op(2, 3, 0, 0, 0, 1'b0);
    run_op(15, 4, 1, 1, 0, 1'b0);
    chk("chain_add_a", 32'(seen_add_a), 5);
    post(1, 1, 0);

    run_op(6, 1, 0, 0, 5, 1'b0);
    post(7, 0, 0);
    chk("bp_op_count", 32'(bus.op_count), 8);
    chk("bp_in_ready", 32'(bus.in_ready), 1);

    run_op(1, 1, 0, 0, 0, 1'b1);
    run_op(9, 4, 0, 1, 0, 1'b0);
    post(4, 0, 0);
    chk("post_rst_count", 32'(bus.op_count), 1);

    for (int i = 0; exp_cnt < 256; i++) begin
      run_op(i % 16, (i * 7) % 16, i % 2,
             (i % 3 == 0) ? 1 : 0, (i % 4 == 0) ? 1 : 0, 1'b0);
    end
    @(negedge clk);
    chk("wrap_op_count", 32'(bus.op_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
